// File: rtl/sig_debounce_pkg.sv
// Shared types and parameter defaults for the sig_debounce input conditioner.
package sig_debounce_pkg;

    typedef enum logic [1:0] {
        LO    = 2'd0,
        LO2HI = 2'd1,
        HI    = 2'd2,
        HI2LO = 2'd3
    } state_t;

    localparam int DEF_STABLE_CNT = 8;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_EVT_W      = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/sig_debounce.sv
// Debouncer: synchronises din, accepts a new level after STABLE_CNT consecutive
// samples, and publishes the clean level, rise/fall strobes and a rising-edge count.
module sig_debounce
    import sig_debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EVT_W      = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_cnt
);

    if (STABLE_CNT < 1 || (1 << CNT_W) < STABLE_CNT) begin : g_bad_params
        $error("sig_debounce: STABLE_CNT must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
    localparam bit               SKIP_WAIT = (STABLE_CNT == 1);

    logic             s2;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LO;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            evt_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            if (rise_nxt) begin
                evt_cnt <= evt_cnt + EVT_W'(1);
            end
        end
    end

    // Any sample matching the current level drops back to the stable state, restarting the count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LO: begin
                if (s2) begin
                    if (SKIP_WAIT) begin
                        state_nxt = HI;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = LO2HI;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            LO2HI: begin
                if (!s2) begin
                    state_nxt = LO;
                end else if (cnt == LAST) begin
                    state_nxt = HI;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (!s2) begin
                    if (SKIP_WAIT) begin
                        state_nxt = LO;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = HI2LO;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            HI2LO: begin
                if (s2) begin
                    state_nxt = HI;
                end else if (cnt == LAST) begin
                    state_nxt = LO;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = LO;
        endcase
    end

    always_comb begin
        dout = (state == HI) || (state == HI2LO);
    end

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: default build and a STABLE_CNT=1 build share one stimulus stream.
module tb_sig_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       dout0, rise0, fall0;
    logic       dout1, rise1, fall1;
    logic [7:0] evt0, evt1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sig_debounce #(.STABLE_CNT(8), .CNT_W(4), .EVT_W(8)) dut0 (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout0), .rise(rise0), .fall(fall0), .evt_cnt(evt0)
    );

    sig_debounce #(.STABLE_CNT(1), .CNT_W(4), .EVT_W(8)) dut1 (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout1), .rise(rise1), .fall(fall1), .evt_cnt(evt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the synchronised sample stream is din delayed two edges; the level
    // flips once the most recent S samples all disagree with the current level.
    int         win_len [2] = '{8, 1};
    logic       m_s1    [2];
    logic       m_s2    [2];
    logic [7:0] m_win   [2];
    int         m_nv    [2];
    logic       m_dout  [2];
    logic       m_rise  [2];
    logic       m_fall  [2];
    logic [7:0] m_evt   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_win[i] = '0; m_nv[i] = 0;
                m_dout[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_evt[i] = '0;
            end else begin
                bit flip;
                m_win[i] = {m_win[i][6:0], m_s2[i]};
                if (m_nv[i] < 8) m_nv[i]++;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                flip = (m_nv[i] >= win_len[i]);
                for (int k = 0; k < win_len[i]; k++)
                    if (m_win[i][k] == m_dout[i]) flip = 1'b0;
                if (flip) begin
                    m_dout[i] = ~m_dout[i];
                    if (m_dout[i]) begin
                        m_rise[i] = 1'b1;
                        m_evt[i]  = m_evt[i] + 8'd1;
                    end else begin
                        m_fall[i] = 1'b1;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = din;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout0", 32'(dout0), 32'(m_dout[0]));
            check("rise0", 32'(rise0), 32'(m_rise[0]));
            check("fall0", 32'(fall0), 32'(m_fall[0]));
            check("evt0",  32'(evt0),  32'(m_evt[0]));
            check("dout1", 32'(dout1), 32'(m_dout[1]));
            check("rise1", 32'(rise1), 32'(m_rise[1]));
            check("fall1", 32'(fall1), 32'(m_fall[1]));
            check("evt1",  32'(evt1),  32'(m_evt[1]));
            check("strobe_excl0", 32'(rise0 & fall0), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held three cycles with din high.
        rst = 1'b1; din = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk_en = 1'b1;
            check("rst_dout", 32'(dout0), 32'd0);
            check("rst_rise", 32'(rise0), 32'd0);
            check("rst_fall", 32'(fall0), 32'd0);
            check("rst_evt",  32'(evt0),  32'd0);
        end
        rst = 1'b0; din = 1'b0;
        tick(4);

        // Clean rise: din set before E1.
        din = 1'b1;
        tick(2);  check("s1_e2_dout",   32'(dout1), 32'd0);
        tick(1);  check("s1_e3_dout",   32'(dout1), 32'd1);
        tick(6);  check("rise_e9_dout", 32'(dout0), 32'd0);
        tick(1);  check("rise_e10_dout", 32'(dout0), 32'd1);
                  check("rise_e10_rise", 32'(rise0), 32'd1);
        tick(1);  check("rise_e11_rise", 32'(rise0), 32'd0);
                  check("rise_e11_evt",  32'(evt0),  32'd1);

        // Fall path.
        din = 1'b0;
        tick(9);  check("fall_e9_dout",  32'(dout0), 32'd1);
        tick(1);  check("fall_e10_fall", 32'(fall0), 32'd1);
                  check("fall_e10_dout", 32'(dout0), 32'd0);
        tick(1);  check("fall_e11_fall", 32'(fall0), 32'd0);
                  check("fall_evt",      32'(evt0),  32'd1);

        // Short glitch rejected, 8-cycle pulse accepted.
        din = 1'b1; tick(5); din = 1'b0; tick(15);
        check("glitch_dout", 32'(dout0), 32'd0);
        check("glitch_evt",  32'(evt0),  32'd1);
        din = 1'b1; tick(8); din = 1'b0; tick(2);
        check("pulse8_rise", 32'(rise0), 32'd1);
        tick(12);
        check("pulse8_evt",  32'(evt0),  32'd2);
        check("pulse8_dout", 32'(dout0), 32'd0);

        // Reset in the middle of the wait: full latency needed again.
        din = 1'b1; tick(5);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("midrst_evt", 32'(evt0), 32'd0);
        tick(9);  check("midrst_e9_rise",  32'(rise0), 32'd0);
        tick(1);  check("midrst_e10_rise", 32'(rise0), 32'd1);
        tick(1);  check("midrst_evt_after", 32'(evt0), 32'd1);
        din = 1'b0; tick(12);

        // Toggling every cycle: default build holds its level.
        for (int c = 0; c < 40; c++) begin
            din = ~din; tick(1);
        end
        check("toggle_dout", 32'(dout0), 32'd0);
        check("toggle_evt",  32'(evt0),  32'd1);
        din = 1'b0; tick(12);

        // 255 more accepted rises wrap the 8-bit counter to zero.
        for (int p = 0; p < 255; p++) begin
            din = 1'b1; tick(10);
            din = 1'b0; tick(10);
        end
        tick(2);
        check("wrap_evt", 32'(evt0), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sig_debounce.md
# sig_debounce

Single-bit input conditioner sitting directly downstream of the registered flop stage (`dout` of that stage drives `din` here). Synchronises the level into `clk`, rejects glitches shorter than `STABLE_CNT` cycles, and publishes a clean level plus single-cycle rise/fall strobes and a rising-edge event counter for the consumer logic.

## Interface
- `STABLE_CNT`, default 8: consecutive cycles a new level must persist before it is accepted; legal range 1..2**CNT_W.
- `CNT_W`, default 4: width of the internal stability counter; must satisfy 2**CNT_W >= STABLE_CNT.
- `EVT_W`, default 8: width of `evt_cnt`.

Ports:
- `clk`  in  1  sole clock; all flops rising-edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `din`  in  1  raw level from the upstream flop; may be asynchronous to `clk`.
- `dout`  out  1  debounced level.
- `rise`  out  1  one-cycle strobe, asserted on the cycle `dout` goes 0->1.
- `fall`  out  1  one-cycle strobe, asserted on the cycle `dout` goes 1->0.
- `evt_cnt`  out  EVT_W  count of accepted rising edges, modulo 2**EVT_W.

## Operation
- Two-flop synchroniser: `s1 <= din; s2 <= s1`. Only `s2` feeds the FSM.
- FSM states: LO, LO2HI, HI, HI2LO. `dout` = 1 in HI and HI2LO, else 0.
- LO: `s2`=1 -> LO2HI with `cnt`=1; else stay, `cnt`=0.
- LO2HI: `s2`=0 -> LO, `cnt`=0 (glitch rejected, no strobe). `s2`=1 and `cnt`==STABLE_CNT-1 -> HI, `cnt`=0, `rise`=1, `evt_cnt`+1. Otherwise `cnt`+1.
- HI / HI2LO: mirror image with `s2`=0 advancing, `fall` strobe, `evt_cnt` unchanged.
- STABLE_CNT=1: LO/HI transitions go directly to HI/LO on the first mismatching `s2` sample (the intermediate state is skipped).
- `rise`, `fall` are registered; never both high; high for exactly one cycle per accepted transition.
- `evt_cnt` wraps 2**EVT_W-1 -> 0 without saturation or flag.

## Timing
- Reset: on any edge with `rst`=1: `s1`,`s2`=0, state LO, `cnt`=0, `dout`=0, `rise`=0, `fall`=0, `evt_cnt`=0. Reset has priority over all other updates, including a transition completing in the same cycle.
- Reset mid-WAIT (LO2HI/HI2LO): partial count discarded; after release a held-high `din` needs the full latency again.
- Latency: `din` stable from before edge E1 -> `s2` valid at E2 -> `dout`/strobe update at edge E(2+STABLE_CNT) (default: 10 edges).
- Any `s2` sample equal to current `dout` during a WAIT state restarts the count; pulses of `s2` shorter than STABLE_CNT cycles produce no output change.
- `din` changing every cycle indefinitely: `dout` holds its value.

## Structure
- Shared package `sig_debounce_pkg`: FSM state enum (LO, LO2HI, HI, HI2LO, 2-bit encoding) and default values for STABLE_CNT/CNT_W/EVT_W.
- Sub-module `sync_2ff` (1-bit, `clk`/`rst`/`d`/`q`), reused by other input stages; the FSM, counters, and strobes stay in the top module.
- Elaboration-time check: error if STABLE_CNT < 1 or 2**CNT_W < STABLE_CNT.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `din`=1 -> `dout`=0, `rise`=0, `fall`=0, `evt_cnt`=0 throughout.
- Clean rise: `din` 0->1 before edge E1, held -> `dout`=1 and `rise`=1 exactly at E10 (default params), `rise`=0 at E11, `evt_cnt`=1.
- Glitch: `din`=1 for 5 cycles, then 0 -> `dout` stays 0, no strobe, `evt_cnt` unchanged; repeat with 8-cycle pulse -> accepted, `rise` once.
- Fall path: from HI, `din`=0 held -> `fall`=1 for one cycle 10 edges later, `dout`=0, `evt_cnt` unchanged.
- Reset mid-operation: `din`=1, assert `rst` at cycle 6 for 1 cycle -> no `rise`; after release, `rise` appears exactly 10 edges after the first post-reset edge.
- Wrap: 256 accepted rising edges with EVT_W=8 -> `evt_cnt` reads 0; STABLE_CNT=1 build: `dout` follows `din` with 3-edge latency.
